// File: rtl/dmem_wait_ctrl_pkg.sv
// Shared types and constants for the wait-state data-memory controller.
// Word-size constants are reused by the multi-cycle CPU.
package dmem_wait_ctrl_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_ADDR_W     = 32;
    localparam int DMEM_WORD_BYTES = DMEM_DATA_W / 8;
    localparam int DMEM_CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous byte-masked write, asynchronous read.
// Contents are not touched by reset.
module dmem_array
    import dmem_wait_ctrl_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W      = $clog2(DEPTH_WORDS),
    localparam int BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory controller with fixed wait-state latency and one-cycle ack.
// Define DMEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module dmem_wait_ctrl
    import dmem_wait_ctrl_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        be,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e           state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  lat_we;
    logic                  lat_mis;
    logic [IDX_W-1:0]      lat_idx;
    logic [DATA_W-1:0]     lat_wdata;
    logic [3:0]            lat_be;

    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_W-1:0]     arr_rdata;
    logic                  arr_we;
    logic                  req_mis;
    logic                  unused_addr;

    assign req_idx = addr[IDX_W+1:2];

    // Only a LATENCY==1 accept reads straight from the live address.
    assign rd_idx = (state == DMEM_IDLE) ? req_idx : lat_idx;

    // A reset landing on the RESP edge drops the in-flight store.
    assign arr_we = (state == DMEM_RESP) && lat_we && !lat_mis && !rst;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_mis     = |addr[1:0];
    assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];
`else
    assign req_mis     = 1'b0;
    assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};
`endif

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .widx  (lat_idx),
        .wdata (lat_wdata),
        .be    (lat_be),
        .ridx  (rd_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DMEM_IDLE;
            ready <= 1'b0;
            ack   <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                DMEM_IDLE: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                    if (req && ready) begin
                        lat_we    <= we;
                        lat_idx   <= req_idx;
                        lat_wdata <= wdata;
                        lat_be    <= be;
                        lat_mis   <= req_mis;
                        cnt       <= DMEM_CNT_W'(LATENCY - 1);
                        ready     <= 1'b0;
                        if (LATENCY == 1) begin
                            state <= DMEM_RESP;
                            ack   <= 1'b1;
                            err   <= req_mis;
                            if (!we) begin
                                rdata <= req_mis ? '0 : arr_rdata;
                            end
                        end else begin
                            state <= DMEM_WAIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == DMEM_CNT_W'(1)) begin
                        state <= DMEM_RESP;
                        ack   <= 1'b1;
                        err   <= lat_mis;
                        if (!lat_we) begin
                            rdata <= lat_mis ? '0 : arr_rdata;
                        end
                    end
                end
                DMEM_RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                    state <= DMEM_IDLE;
                end
                default: begin
                    state <= DMEM_IDLE;
                end
            endcase
        end
    end

endmodule
